// File: rtl/border_tx_arbiter_if.sv
// Handshake bundle between the control FIFO, the border channels and the parent link.
// The arbiter connects through the slave modport; the sources and sink use master.
interface border_tx_arbiter_if #(
    parameter int NUM_CHANNELS   = 30,
    parameter int FPGA_FIFO_SIZE = 12
);
    logic [NUM_CHANNELS*FPGA_FIFO_SIZE-1:0] border_data;
    logic [NUM_CHANNELS-1:0]                border_valid;
    logic [NUM_CHANNELS-1:0]                border_ready;
    logic [63:0]                            ctrl_data;
    logic                                   ctrl_valid;
    logic                                   ctrl_ready;
    logic [63:0]                            out_data;
    logic                                   out_valid;
    logic                                   out_ready;

    modport master (
        output border_data, border_valid, ctrl_data, ctrl_valid, out_ready,
        input  border_ready, ctrl_ready, out_data, out_valid
    );

    modport slave (
        input  border_data, border_valid, ctrl_data, ctrl_valid, out_ready,
        output border_ready, ctrl_ready, out_data, out_valid
    );
endinterface

// File: rtl/border_tx_arbiter.sv
// Parent-link arbiter: control words pass verbatim, border payloads are framed with a tag
// header; round-robin across border channels with a cap on consecutive control grants.
module border_tx_arbiter #(
    parameter int          NUM_CHANNELS   = 30,
    parameter int          FPGA_FIFO_SIZE = 12,
    parameter int          CTRL_BURST_MAX = 4,
    parameter logic [7:0]  BORDER_TAG     = 8'hFE
) (
    input  logic                 clk,
    input  logic                 reset,
    border_tx_arbiter_if.slave   link,
    output logic                 busy,
    output logic [15:0]          ctrl_count,
    output logic [15:0]          border_count
);
    localparam int PTR_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int BURST_W = (CTRL_BURST_MAX > 0) ? $clog2(CTRL_BURST_MAX + 1) : 1;
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(CTRL_BURST_MAX);
    localparam logic [PTR_W:0]     NUM_CH_EXT = (PTR_W + 1)'(NUM_CHANNELS);
    localparam logic [PTR_W-1:0]   LAST_CH    = PTR_W'(NUM_CHANNELS - 1);

    logic                  out_valid_q, out_valid_d;
    logic [63:0]           out_data_q, out_data_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [15:0]           ctrl_count_q, ctrl_count_d;
    logic [15:0]           border_count_q, border_count_d;

    logic                  load_en;
    logic                  any_border;
    logic                  ctrl_wins;
    logic                  ctrl_grant;
    logic                  border_grant;
    logic [2*NUM_CHANNELS-1:0] valid_rot;
    logic [PTR_W-1:0]      rr_offset;
    logic [PTR_W:0]        grant_sum;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_CHANNELS-1:0] grant_onehot;
    logic [31:0]           payload_ext [NUM_CHANNELS];
    logic [31:0]           grant_payload;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign payload_ext[gi]  = 32'(link.border_data[gi*FPGA_FIFO_SIZE +: FPGA_FIFO_SIZE]);
            assign grant_onehot[gi] = (grant_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        load_en      = !out_valid_q || link.out_ready;
        any_border   = |link.border_valid;
        ctrl_wins    = link.ctrl_valid && !((burst_cnt_q == BURST_MAX) && any_border);
        // Readies are forced low while reset is asserted so nothing is popped and lost.
        ctrl_grant   = reset && load_en && ctrl_wins;
        border_grant = reset && load_en && !ctrl_wins && any_border;

        // Rotate the valids so bit 0 is the channel at rr_ptr; lowest set bit is the winner.
        valid_rot = {link.border_valid, link.border_valid} >> rr_ptr_q;
        rr_offset = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                rr_offset = PTR_W'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, rr_offset};
        if (grant_sum >= NUM_CH_EXT) begin
            grant_sum = grant_sum - NUM_CH_EXT;
        end
        grant_idx = grant_sum[PTR_W-1:0];

        grant_payload = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            grant_payload = grant_payload | (payload_ext[k] & {32{grant_onehot[k]}});
        end
    end

    assign link.ctrl_ready   = ctrl_grant;
    assign link.border_ready = {NUM_CHANNELS{border_grant}} & grant_onehot;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        rr_ptr_d       = rr_ptr_q;
        burst_cnt_d    = burst_cnt_q;
        ctrl_count_d   = ctrl_count_q;
        border_count_d = border_count_q;

        if (ctrl_grant) begin
            out_valid_d  = 1'b1;
            out_data_d   = link.ctrl_data;
            ctrl_count_d = (ctrl_count_q == 16'hFFFF) ? ctrl_count_q : ctrl_count_q + 16'd1;
        end else if (border_grant) begin
            out_valid_d    = 1'b1;
            out_data_d     = {BORDER_TAG, 8'h00, 16'(grant_idx), grant_payload};
            rr_ptr_d       = (grant_idx == LAST_CH) ? '0 : grant_idx + PTR_W'(1);
            border_count_d = (border_count_q == 16'hFFFF) ? border_count_q : border_count_q + 16'd1;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end

        // The burst count only measures control grants made while border traffic waits.
        if (!any_border || border_grant) begin
            burst_cnt_d = '0;
        end else if (ctrl_grant) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            rr_ptr_q       <= '0;
            burst_cnt_q    <= '0;
            ctrl_count_q   <= '0;
            border_count_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            rr_ptr_q       <= rr_ptr_d;
            burst_cnt_q    <= burst_cnt_d;
            ctrl_count_q   <= ctrl_count_d;
            border_count_q <= border_count_d;
        end
    end

    assign link.out_valid = out_valid_q;
    assign link.out_data  = out_data_q;
    assign busy           = link.ctrl_valid || any_border || out_valid_q;
    assign ctrl_count     = ctrl_count_q;
    assign border_count   = border_count_q;
endmodule
